// File: rtl/fifo_cts_if.sv
// fifo_cts_if: RTS/CTS flit link plus local read grants and FIFO status; err_out only with FIFO_ERR_FLAGS_EN
interface fifo_cts_if #(parameter int DATA_WIDTH = 32);
   logic [DATA_WIDTH-1:0] RX;
   logic [DATA_WIDTH-1:0] Data_out;
   logic DRTS;
   logic CTS;
   logic read_en_N;
   logic read_en_E;
   logic read_en_W;
   logic read_en_S;
   logic read_en_L;
   logic empty_out;
   logic full_out;
`ifdef FIFO_ERR_FLAGS_EN
   logic err_out;
   modport master (
      output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
      input  CTS, Data_out, empty_out, full_out, err_out
   );
   modport slave (
      input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
      output CTS, Data_out, empty_out, full_out, err_out
   );
`else
   modport master (
      output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
      input  CTS, Data_out, empty_out, full_out
   );
   modport slave (
      input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
      output CTS, Data_out, empty_out, full_out
   );
`endif
endinterface

// File: rtl/fifo_cts.sv
// fifo_cts: RTS/CTS input-port flit FIFO with first-word fall-through; FIFO_ERR_FLAGS_EN adds sticky err_out
module fifo_cts #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input logic     clk,
   input logic     rst,
   fifo_cts_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic                  cts_q;
   logic [4:0]            rd_vec;
   logic                  any_rd, wr, rd;

   assign rd_vec        = {bus.read_en_N, bus.read_en_E, bus.read_en_W, bus.read_en_S, bus.read_en_L};
   assign any_rd        = |rd_vec;
   assign bus.full_out  = count == FULL_CNT;
   assign bus.empty_out = count == '0;
   // ~cts_q blocks a second write of the flit the sender still holds during the CTS cycle
   assign wr            = bus.DRTS & ~cts_q & ~bus.full_out;
   assign rd            = any_rd & ~bus.empty_out;
   assign bus.CTS       = cts_q;
   assign bus.Data_out  = mem[rd_ptr];

   // flit storage, deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= bus.RX;
   end

   // pointers, occupancy and the one-cycle CTS acknowledgement
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cts_q  <= 1'b0;
      end else begin
         cts_q <= wr;
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic err_q;
   assign bus.err_out = err_q;

   // sticky flag for a read grant while empty or for multiple simultaneous grants
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_q | (any_rd & bus.empty_out) | ~$onehot0(rd_vec);
   end
`endif
endmodule
